// File: rtl/mem_port_b_arbiter.sv
// Per-cycle request/grant arbiter for memory port B, shared by the host interface and the multiplier engine.
// The engine has priority, the host gets a bounded-starvation slot, and an engine lock can extend a burst.
module mem_port_b_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,

    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    input  logic                  eng_lock,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [DATA_WIDTH-1:0] eng_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                  last_eng_q,   last_eng_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  rd_host_q,    rd_host_d;
    logic                  rd_eng_q,     rd_eng_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    logic contended;
    logic locked;

    assign contended = host_req & eng_req;
    // A lock only extends a grant the engine already held on the previous cycle.
    assign locked    = eng_lock & last_eng_q;

    always_comb begin
        host_gnt = 1'b0;
        eng_gnt  = 1'b0;
        if (contended) begin
            if (locked) begin
                eng_gnt = 1'b1;
            end else if (starve_cnt_q == HOLD_MAX) begin
                host_gnt = 1'b1;
            end else begin
                eng_gnt = 1'b1;
            end
        end else if (eng_req) begin
            eng_gnt = 1'b1;
        end else if (host_req) begin
            host_gnt = 1'b1;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_gnt || !host_req) begin
            starve_cnt_d = '0;
        end else if (eng_gnt && (starve_cnt_q != HOLD_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end
    end

    // Address and data hold their last driven value on idle cycles.
    always_comb begin
        mem_addr = hold_addr_q;
        mem_data = hold_data_q;
        mem_we   = 1'b0;
        if (host_gnt) begin
            mem_addr = host_addr;
            mem_data = host_wdata;
            mem_we   = host_we;
        end else if (eng_gnt) begin
            mem_addr = eng_addr;
            mem_data = eng_wdata;
            mem_we   = eng_we;
        end
    end

    assign last_eng_d = eng_gnt;
    assign rd_host_d  = host_gnt & ~host_we;
    assign rd_eng_d   = eng_gnt & ~eng_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_eng_q   <= 1'b0;
            starve_cnt_q <= '0;
            rd_host_q    <= 1'b0;
            rd_eng_q     <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            last_eng_q   <= last_eng_d;
            starve_cnt_q <= starve_cnt_d;
            rd_host_q    <= rd_host_d;
            rd_eng_q     <= rd_eng_d;
            hold_addr_q  <= mem_addr;
            hold_data_q  <= mem_data;
        end
    end

    // Read data is shared; the rvalid tag tells each consumer whether it is theirs.
    assign host_rvalid = rd_host_q;
    assign eng_rvalid  = rd_eng_q;
    assign host_rdata  = mem_q;
    assign eng_rdata   = mem_q;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Scoreboard bench for mem_port_b_arbiter: directed stimulus pushes expected read returns,
// a negedge monitor pops them when rvalid appears; grants and memory drive are checked per step.
module tb_mem_port_b_arbiter;

    logic        clk;
    logic        reset;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [11:0] host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        eng_req, eng_we, eng_lock, eng_gnt, eng_rvalid;
    logic [11:0] eng_addr;
    logic [31:0] eng_wdata, eng_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_data, mem_q;
    logic        mem_we;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         host_q[$];
    rd_t         eng_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [11:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] mem [0:4095];

    mem_port_b_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_lock(eng_lock), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory model; contents are (re)loaded while reset is held.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[12'h010] <= 32'hDEADBEEF;
            mem[12'h020] <= 32'hA5A50020;
            mem[12'h030] <= 32'h12345678;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_data;
            mem_q <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk1("grant_exclusive_we_qualified",
                 (host_gnt & eng_gnt) | (mem_we & ~(host_gnt | eng_gnt)), 1'b0);
            while (host_q.size() > 0 && host_q[0].due < cyc) begin
                chk1("host_rvalid_missing", 1'b0, 1'b1);
                void'(host_q.pop_front());
            end
            while (eng_q.size() > 0 && eng_q[0].due < cyc) begin
                chk1("eng_rvalid_missing", 1'b0, 1'b1);
                void'(eng_q.pop_front());
            end
            if (host_rvalid) begin
                if (host_q.size() == 0 || host_q[0].due != cyc) begin
                    chk1("host_rvalid_unexpected", host_rvalid, 1'b0);
                end else begin
                    chk("host_rdata", host_rdata, host_q[0].data);
                    void'(host_q.pop_front());
                end
            end
            if (eng_rvalid) begin
                if (eng_q.size() == 0 || eng_q[0].due != cyc) begin
                    chk1("eng_rvalid_unexpected", eng_rvalid, 1'b0);
                end else begin
                    chk("eng_rdata", eng_rdata, eng_q[0].data);
                    void'(eng_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic hr, input logic hwe, input logic [11:0] ha, input logic [31:0] hd,
                        input logic er, input logic ewe, input logic [11:0] ea, input logic [31:0] ed,
                        input logic el, input logic exp_hg, input logic exp_eg,
                        input logic [31:0] hexp, input logic [31:0] eexp);
        logic [11:0] xa;
        logic [31:0] xd;
        @(posedge clk);
        #1;
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
        eng_req = er; eng_we = ewe; eng_addr = ea; eng_wdata = ed; eng_lock = el;
        if (exp_hg && !hwe) host_q.push_back('{cyc + 1, hexp});
        if (exp_eg && !ewe) eng_q.push_back('{cyc + 1, eexp});
        @(negedge clk);
        chk1("host_gnt", host_gnt, exp_hg);
        chk1("eng_gnt", eng_gnt, exp_eg);
        chk1("mem_we", mem_we, (exp_hg & hwe) | (exp_eg & ewe));
        xa = last_addr;
        xd = last_data;
        if (exp_hg) begin
            xa = ha; xd = hd;
        end else if (exp_eg) begin
            xa = ea; xd = ed;
        end
        chk("mem_addr", 32'(mem_addr), 32'(xa));
        chk("mem_data", mem_data, xd);
        last_addr = xa;
        last_data = xd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0; eng_lock = 0;
        #2;
        chk1("reset_host_rvalid", host_rvalid, 1'b0);
        chk1("reset_eng_rvalid", eng_rvalid, 1'b0);
        chk1("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        #20;
        reset = 1'b1;

        // Host-only read
        step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
        idle(1);

        // Engine write with host idle, then host reads it back
        step(0, 0, 12'h0, 32'h0, 1, 1, 12'h0FF, 32'h00000005, 0, 0, 1, 32'h0, 32'h0);
        step(1, 0, 12'h0FF, 32'h0, 0, 0, 12'h0, 32'h0, 0, 1, 0, 32'h00000005, 32'h0);

        // Idle: no grants, address holds 0x0FF
        idle(4);

        // Fairness: host forced in every 9th contended cycle
        for (int k = 1; k <= 19; k++) begin
            step(1, 0, 12'h010, 32'h1, 1, 0, 12'h020, 32'h2, 0,
                 (k % 9) == 0, (k % 9) != 0, 32'hDEADBEEF, 32'hA5A50020);
        end
        idle(1);

        // Lock: counter saturates, lock holds the engine 5 more cycles, then host
        for (int k = 1; k <= 8; k++)
            step(1, 0, 12'h010, 32'h1, 1, 0, 12'h020, 32'h2, 0, 0, 1, 32'hDEADBEEF, 32'hA5A50020);
        for (int k = 1; k <= 5; k++)
            step(1, 0, 12'h010, 32'h1, 1, 0, 12'h020, 32'h2, 1, 0, 1, 32'hDEADBEEF, 32'hA5A50020);
        step(1, 0, 12'h010, 32'h1, 1, 0, 12'h020, 32'h2, 0, 1, 0, 32'hDEADBEEF, 32'hA5A50020);
        step(1, 0, 12'h010, 32'h1, 1, 0, 12'h020, 32'h2, 0, 0, 1, 32'hDEADBEEF, 32'hA5A50020);
        // eng_lock without eng_req does not block the host
        step(1, 0, 12'h030, 32'h1, 0, 0, 12'h020, 32'h2, 1, 1, 0, 32'h12345678, 32'h0);
        idle(1);

        // Reset in the cycle after a granted engine read
        step(0, 0, 12'h0, 32'h0, 1, 0, 12'h030, 32'h2, 0, 0, 1, 32'h0, 32'h12345678);
        @(posedge clk);
        #1;
        chk1("eng_rvalid_before_reset", eng_rvalid, 1'b1);
        #2;
        host_req = 0; eng_req = 0; eng_lock = 0;
        reset = 1'b0;
        void'(eng_q.pop_back());
        #1;
        chk1("eng_rvalid_in_reset", eng_rvalid, 1'b0);
        chk1("mem_we_in_reset", mem_we, 1'b0);
        chk("mem_addr_in_reset", 32'(mem_addr), 32'h0);
        last_addr = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 0, 12'h010, 32'h1, 1, 0, 12'h030, 32'h2, 0, 0, 1, 32'hDEADBEEF, 32'h12345678);
        idle(3);

        chk("host_q_drained", 32'(host_q.size()), 32'h0);
        chk("eng_q_drained", 32'(eng_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_b_arbiter.md
Name: mem_port_b_arbiter

Overview:
- Shares port B of the dual-port matrix memory between two requesters: the external host interface and the multiplier engine.
- Replaces the static is_working mux with a per-cycle request/grant arbiter:
  - engine has priority;
  - host has bounded-starvation fairness;
  - engine can lock the port for atomic bursts;
  - read-return routing follows the 1-cycle synchronous memory read.
- Sits between matrix_multiplier top-level I/O, the multiplier engine and memory port B.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 12, memory address width
MAX_HOLD, 8, max consecutive engine grants while host waits before host is forced one grant (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
host_req  input  1  host requests port B this cycle
host_we  input  1  host write (1) / read (0)
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  DATA_WIDTH  host write data
host_gnt  output  1  host owns port B this cycle (combinational)
host_rvalid  output  1  host read data valid on host_rdata
host_rdata  output  DATA_WIDTH  read data to host
eng_req  input  1  engine requests port B
eng_we  input  1  engine write/read
eng_addr  input  ADDR_WIDTH  engine address
eng_wdata  input  DATA_WIDTH  engine write data
eng_lock  input  1  engine requests to keep port on next cycle
eng_gnt  output  1  engine owns port B this cycle (combinational)
eng_rvalid  output  1  engine read data valid
eng_rdata  output  DATA_WIDTH  read data to engine
mem_addr  output  ADDR_WIDTH  to memory addr_b
mem_data  output  DATA_WIDTH  to memory data_b
mem_we  output  1  to memory we_b
mem_q  input  DATA_WIDTH  from memory q_b (valid 1 cycle after read address)

Behaviour:
- State registers:
  - last_eng: previous cycle granted engine.
  - starve_cnt: width clog2(MAX_HOLD+1).
  - rd_host, rd_eng: read-return tags.
- Reset (reset=0, async): last_eng=0, starve_cnt=0, rd_host=0, rd_eng=0. Hence host_rvalid=0, eng_rvalid=0. An in-flight read is dropped and never returns.
- Grant decision (combinational, at most one grant per cycle):
  - Neither requester: no grant.
  - Only one requester: that one is granted.
  - Both, with eng_lock=1 and last_eng=1: engine granted (lock honoured regardless of counter).
  - Both, with starve_cnt==MAX_HOLD and not locked: host granted.
  - Both, otherwise: engine granted.
- eng_lock without eng_req has no effect. Lock takes effect only if the engine was granted in the previous cycle.
- starve_cnt update (registered):
  - +1 when eng_gnt and host_req, saturating at MAX_HOLD.
  - Cleared to 0 when host_gnt, or when host_req=0.
- last_eng <= eng_gnt every cycle. An idle cycle clears it, so the lock chain breaks.
- Memory drive:
  - Granted requester's addr/wdata/we routed to mem_*.
  - With no grant: mem_we=0; mem_addr/mem_data hold their last driven values (registered hold, reset 0).
  - mem_we never 1 without a grant.
- Writes complete on the grant edge and produce no rvalid.
- Read return:
  - rd_host <= host_gnt & ~host_we; rd_eng <= eng_gnt & ~eng_we.
  - host_rvalid = rd_host, eng_rvalid = rd_eng.
  - host_rdata = eng_rdata = mem_q, unqualified; rvalid selects the consumer.
  - Latency: exactly 1 cycle from granted read to rvalid. Back-to-back reads are sustained at 1 per cycle. Ownership may switch every cycle with no bubble.
- Requester contract:
  - A requester holds req/addr/we/data until it sees gnt.
  - A request without gnt is not performed and has no side effect.

Test Plan:
- Host-only read: mem[0x010]=0xDEADBEEF; host_req=1, we=0, addr=0x010 for 1 cycle -> host_gnt=1 same cycle; next cycle host_rvalid=1, host_rdata=0xDEADBEEF; eng_rvalid=0.
- Fairness (MAX_HOLD=8): host_req and eng_req held high, engine reads -> eng_gnt for 8 cycles, host_gnt on cycle 9, engine regranted on cycle 10, pattern repeats with period 9.
- Lock: starve_cnt at 8, eng_lock=1 with engine granted the previous cycle -> engine keeps grant for 5 more cycles while lock held; lock drops -> host granted the next cycle.
- Write routing: engine writes 0x00000005 to 0x0FF while host idle -> mem_we=1, mem_addr=0x0FF, mem_data=5 for one cycle; no rvalid; host then reads 0x0FF -> 5.
- Reset mid-operation: assert reset low asynchronously in the cycle after a granted engine read -> eng_rvalid=0 immediately; after release, starve_cnt=0 and the first contended grant goes to the engine.
- Idle: no requests for 4 cycles -> mem_we=0, no grants, mem_addr holds its last value, no rvalid.
